// File: rtl/bj_redirect_ctrl.sv
// bj_redirect_ctrl: branch/jump resolution and fetch-redirect controller at ID/EX.
// Takes one decoded branch op from ID, resolves it one cycle later (EVAL),
// writes the link register for BL/JIRL, then holds a redirect to IF until it is
// accepted. A misaligned taken target raises br_adef instead of redirecting.
// ex_flush aborts any in-flight operation.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   id_valid/id_ready           branch op handshake from ID (id_ready combinational)
//   id_op/id_inst/id_pc         decoded op, raw instruction, instruction PC
//   rj_value/rkd_value          GR[rj], GR[rd] operands
//   ex_flush                    exception/ertn flush, highest priority
//   br_valid/br_ready/br_target redirect request to IF
//   flush_id                    one-cycle squash of IF/ID
//   br_adef                     one-cycle misaligned taken target
//   link_we/link_addr/link_data link register write (EVAL cycle)
//   stat_bj_cnt/stat_taken_cnt  statistics counters
//
// Optional feature: define BJ_STAT_EN to build the statistics counters;
// otherwise both stat ports are constant 0.

`ifndef OP_INVALID
`define OP_INVALID 8'h00
`define OP_JIRL    8'h01
`define OP_B       8'h02
`define OP_BL      8'h03
`define OP_BEQ     8'h04
`define OP_BNE     8'h05
`define OP_BLT     8'h06
`define OP_BGE     8'h07
`define OP_BLTU    8'h08
`define OP_BGEU    8'h09
`endif

module bj_redirect_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [7:0]  id_op,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] rj_value,
  input  logic [31:0] rkd_value,
  input  logic        ex_flush,
  output logic        br_valid,
  input  logic        br_ready,
  output logic [31:0] br_target,
  output logic        flush_id,
  output logic        br_adef,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic [31:0] stat_bj_cnt,
  output logic [31:0] stat_taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [25:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] rj_q;
  logic [31:0] rkd_q;
  logic        adef_q;
  logic [31:0] br_target_q;
  logic [4:0]  link_addr_q;
  logic [31:0] link_data_q;

  logic [31:0] offs16;
  logic [31:0] offs26;
  logic [31:0] target;
  logic        taken;
  logic        handshake;

  // Opcode bits above the immediate field carry nothing this block needs.
  logic        unused_bits;
  assign unused_bits = &{1'b0, id_inst[31:26]};

  // Branch offsets from the registered instruction.
  assign offs16 = {{14{inst_q[25]}}, inst_q[25:10], 2'b00};
  assign offs26 = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b00};

  // Condition and target resolution on the registered fields.
  always_comb begin
    taken  = 1'b0;
    target = pc_q + offs16;
    case (op_q)
      `OP_B:    begin taken = 1'b1; target = pc_q + offs26; end
      `OP_BL:   begin taken = 1'b1; target = pc_q + offs26; end
      `OP_JIRL: begin taken = 1'b1; target = rj_q + offs16; end
      `OP_BEQ:  taken = (rj_q == rkd_q);
      `OP_BNE:  taken = (rj_q != rkd_q);
      `OP_BLT:  taken = ($signed(rj_q) <  $signed(rkd_q));
      `OP_BGE:  taken = ($signed(rj_q) >= $signed(rkd_q));
      `OP_BLTU: taken = (rj_q <  rkd_q);
      `OP_BGEU: taken = (rj_q >= rkd_q);
      default:  taken = 1'b0;
    endcase
  end

  // A handshake coincident with ex_flush is void.
  assign handshake = (state == REDIR) && br_ready && !ex_flush;

  // Control FSM and operand capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      op_q        <= `OP_INVALID;
      inst_q      <= 26'd0;
      pc_q        <= 32'd0;
      rj_q        <= 32'd0;
      rkd_q       <= 32'd0;
      adef_q      <= 1'b0;
      br_target_q <= 32'd0;
      link_addr_q <= 5'd0;
      link_data_q <= 32'd0;
    end else begin
      adef_q <= 1'b0;
      if (ex_flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (id_valid) begin
              op_q        <= id_op;
              inst_q      <= id_inst[25:0];
              pc_q        <= id_pc;
              rj_q        <= rj_value;
              rkd_q       <= rkd_value;
              link_data_q <= id_pc + 32'd4;
              // A zero link address doubles as "no link write".
              if (id_op == `OP_BL)        link_addr_q <= 5'd1;
              else if (id_op == `OP_JIRL) link_addr_q <= id_inst[4:0];
              else                        link_addr_q <= 5'd0;
              state <= EVAL;
            end
          end
          EVAL: begin
            if (taken && (target[1:0] == 2'b00)) begin
              br_target_q <= target;
              state       <= REDIR;
            end else begin
              adef_q <= taken;
              state  <= IDLE;
            end
          end
          REDIR: begin
            if (br_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign id_ready  = (state == IDLE) && !ex_flush;
  assign br_valid  = (state == REDIR) && !ex_flush;
  assign br_target = br_target_q;
  assign br_adef   = adef_q && !ex_flush;
  assign flush_id  = !ex_flush && (adef_q || ((state == REDIR) && br_ready));
  assign link_we   = (state == EVAL) && (link_addr_q != 5'd0) && !ex_flush;
  assign link_addr = link_addr_q;
  assign link_data = link_data_q;

`ifdef BJ_STAT_EN
  logic [31:0] bj_cnt_q;
  logic [31:0] taken_cnt_q;

  // Resolved-branch and accepted-redirect counters, wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bj_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      if ((state == EVAL) && !ex_flush) bj_cnt_q <= bj_cnt_q + 32'd1;
      if (handshake) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign stat_bj_cnt    = bj_cnt_q;
  assign stat_taken_cnt = taken_cnt_q;
`else
  assign stat_bj_cnt    = 32'd0;
  assign stat_taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// Self-checking bench for bj_redirect_ctrl: directed scenarios followed by
// randomized branches checked against a behavioural resolution model.
`timescale 1ns/1ps

`ifndef OP_INVALID
`define OP_INVALID 8'h00
`define OP_JIRL    8'h01
`define OP_B       8'h02
`define OP_BL      8'h03
`define OP_BEQ     8'h04
`define OP_BNE     8'h05
`define OP_BLT     8'h06
`define OP_BGE     8'h07
`define OP_BLTU    8'h08
`define OP_BGEU    8'h09
`endif

module tb_bj_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic        id_ready;
  logic [7:0]  id_op;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] rj_value;
  logic [31:0] rkd_value;
  logic        ex_flush;
  logic        br_valid;
  logic        br_ready;
  logic [31:0] br_target;
  logic        flush_id;
  logic        br_adef;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic [31:0] stat_bj_cnt;
  logic [31:0] stat_taken_cnt;

  int checks    = 0;
  int failures  = 0;
  int exp_bj    = 0;
  int exp_taken = 0;

  always #5 clk = ~clk;

  bj_redirect_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_op          (id_op),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .rj_value       (rj_value),
    .rkd_value      (rkd_value),
    .ex_flush       (ex_flush),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_target      (br_target),
    .flush_id       (flush_id),
    .br_adef        (br_adef),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .link_data      (link_data),
    .stat_bj_cnt    (stat_bj_cnt),
    .stat_taken_cnt (stat_taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string nm);
`ifdef BJ_STAT_EN
    chk({nm, ".stat_bj"},    stat_bj_cnt,    32'(exp_bj));
    chk({nm, ".stat_taken"}, stat_taken_cnt, 32'(exp_taken));
`else
    chk({nm, ".stat_bj"},    stat_bj_cnt,    32'd0);
    chk({nm, ".stat_taken"}, stat_taken_cnt, 32'd0);
`endif
  endtask

  // Architectural branch resolution, computed with integer arithmetic.
  function automatic void model(input logic [7:0] op, input logic [31:0] inst,
                                input logic [31:0] pc, input logic [31:0] rj,
                                input logic [31:0] rkd, output logic taken,
                                output logic [31:0] tgt, output logic [4:0] la);
    logic [15:0] i16;
    logic [25:0] i26;
    int          o16;
    int          o26;
    i16 = inst[25:10];
    i26 = {inst[9:0], inst[25:10]};
    o16 = int'($signed(i16)) * 4;
    o26 = int'($signed(i26)) * 4;
    taken = 1'b0;
    tgt   = pc + 32'(o16);
    la    = 5'd0;
    case (op)
      `OP_B:    begin taken = 1'b1; tgt = pc + 32'(o26); end
      `OP_BL:   begin taken = 1'b1; tgt = pc + 32'(o26); la = 5'd1; end
      `OP_JIRL: begin taken = 1'b1; tgt = rj + 32'(o16); la = inst[4:0]; end
      `OP_BEQ:  taken = (rj == rkd);
      `OP_BNE:  taken = (rj != rkd);
      `OP_BLT:  taken = (int'(rj) <  int'(rkd));
      `OP_BGE:  taken = (int'(rj) >= int'(rkd));
      `OP_BLTU: taken = (longint'({32'd0, rj}) <  longint'({32'd0, rkd}));
      `OP_BGEU: taken = (longint'({32'd0, rj}) >= longint'({32'd0, rkd}));
      default:  taken = 1'b0;
    endcase
  endfunction

  // One complete branch: accept, EVAL, then redirect / adef / fall-through.
  task automatic run_branch(input string nm, input logic [7:0] op, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [31:0] rj,
                            input logic [31:0] rkd, input int rdy_delay);
    logic        taken;
    logic [31:0] tgt;
    logic [4:0]  la;
    model(op, inst, pc, rj, rkd, taken, tgt, la);
    id_valid  = 1'b1;
    id_op     = op;
    id_inst   = inst;
    id_pc     = pc;
    rj_value  = rj;
    rkd_value = rkd;
    #1;
    chk({nm, ".id_ready_t"}, 32'(id_ready), 32'd1);
    tick();
    id_valid  = 1'b0;
    id_inst   = $urandom;
    rj_value  = $urandom;
    #1;
    chk({nm, ".link_we"}, 32'(link_we), 32'(la != 5'd0));
    if (la != 5'd0) begin
      chk({nm, ".link_addr"}, 32'(link_addr), 32'(la));
      chk({nm, ".link_data"}, link_data, pc + 32'd4);
    end
    chk({nm, ".br_valid_t1"}, 32'(br_valid), 32'd0);
    chk({nm, ".id_ready_t1"}, 32'(id_ready), 32'd0);
    tick();
    exp_bj++;
    #1;
    if (taken && (tgt[1:0] == 2'b00)) begin
      for (int i = 0; i < rdy_delay; i++) begin
        chk({nm, ".br_valid_wait"},  32'(br_valid), 32'd1);
        chk({nm, ".br_target_wait"}, br_target, tgt);
        chk({nm, ".flush_id_wait"},  32'(flush_id), 32'd0);
        tick();
        #1;
      end
      br_ready = 1'b1;
      #1;
      chk({nm, ".br_valid_hs"},  32'(br_valid), 32'd1);
      chk({nm, ".br_target_hs"}, br_target, tgt);
      chk({nm, ".flush_id_hs"},  32'(flush_id), 32'd1);
      tick();
      br_ready = 1'b0;
      exp_taken++;
      #1;
      chk({nm, ".br_valid_post"}, 32'(br_valid), 32'd0);
      chk({nm, ".id_ready_post"}, 32'(id_ready), 32'd1);
      chk({nm, ".flush_id_post"}, 32'(flush_id), 32'd0);
    end else if (taken) begin
      chk({nm, ".br_adef"},       32'(br_adef),  32'd1);
      chk({nm, ".flush_id_adef"}, 32'(flush_id), 32'd1);
      chk({nm, ".br_valid_adef"}, 32'(br_valid), 32'd0);
      chk({nm, ".id_ready_adef"}, 32'(id_ready), 32'd1);
      tick();
      #1;
      chk({nm, ".br_adef_post"},  32'(br_adef),  32'd0);
      chk({nm, ".flush_id_post"}, 32'(flush_id), 32'd0);
    end else begin
      chk({nm, ".br_valid_nt"}, 32'(br_valid), 32'd0);
      chk({nm, ".id_ready_nt"}, 32'(id_ready), 32'd1);
      chk({nm, ".br_adef_nt"},  32'(br_adef),  32'd0);
      chk({nm, ".flush_id_nt"}, 32'(flush_id), 32'd0);
    end
    chk_stats(nm);
  endtask

  initial begin
    logic [7:0] ops [10];
    ops = '{`OP_INVALID, `OP_JIRL, `OP_B, `OP_BL, `OP_BEQ,
            `OP_BNE, `OP_BLT, `OP_BGE, `OP_BLTU, `OP_BGEU};

    resetn    = 1'b0;
    id_valid  = 1'b0;
    id_op     = `OP_INVALID;
    id_inst   = 32'd0;
    id_pc     = 32'd0;
    rj_value  = 32'd0;
    rkd_value = 32'd0;
    ex_flush  = 1'b0;
    br_ready  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("rst.br_valid",  32'(br_valid),  32'd0);
    chk("rst.flush_id",  32'(flush_id),  32'd0);
    chk("rst.br_adef",   32'(br_adef),   32'd0);
    chk("rst.link_we",   32'(link_we),   32'd0);
    chk("rst.link_addr", 32'(link_addr), 32'd0);
    chk("rst.link_data", link_data,      32'd0);
    chk("rst.br_target", br_target,      32'd0);
    chk("rst.id_ready",  32'(id_ready),  32'd1);
    chk_stats("rst");

    // Taken BEQ with three cycles of IF back-pressure.
    run_branch("beq", `OP_BEQ, 32'h0000_1000, 32'h1C00_0100, 32'd5, 32'd5, 3);
    // Signed vs unsigned compare on the same operands.
    run_branch("blt",  `OP_BLT,  32'h0000_1000, 32'h1C00_0200, 32'hFFFF_FFFF, 32'd1, 0);
    run_branch("bltu", `OP_BLTU, 32'h0000_1000, 32'h1C00_0200, 32'hFFFF_FFFF, 32'd1, 0);
    // BL with offs26 = -1.
    run_branch("bl", `OP_BL, 32'h03FF_FFFF, 32'h1C00_0000, 32'd0, 32'd0, 1);
    chk("bl.target_hold", br_target, 32'h1BFF_FFFC);
    // JIRL to a misaligned target with rd=0.
    run_branch("jirl", `OP_JIRL, 32'h0000_0060, 32'h1C00_0300, 32'h1C00_0002, 32'd0, 0);
    run_branch("invalid", `OP_INVALID, 32'h0000_1000, 32'h1C00_0400, 32'd7, 32'd7, 0);

    // ex_flush coincident with the redirect handshake.
    id_valid = 1'b1; id_op = `OP_BEQ; id_inst = 32'h0000_1000;
    id_pc = 32'h1C00_0500; rj_value = 32'd9; rkd_value = 32'd9;
    tick();
    id_valid = 1'b0;
    tick();
    exp_bj++;
    #1;
    chk("exf_redir.br_valid", 32'(br_valid), 32'd1);
    br_ready = 1'b1;
    ex_flush = 1'b1;
    #1;
    chk("exf_redir.flush_id", 32'(flush_id), 32'd0);
    chk("exf_redir.br_valid_gated", 32'(br_valid), 32'd0);
    chk("exf_redir.id_ready_gated", 32'(id_ready), 32'd0);
    tick();
    br_ready = 1'b0;
    ex_flush = 1'b0;
    #1;
    chk("exf_redir.br_valid_post", 32'(br_valid), 32'd0);
    chk("exf_redir.id_ready_post", 32'(id_ready), 32'd1);
    chk("exf_redir.flush_id_post", 32'(flush_id), 32'd0);
    chk_stats("exf_redir");

    // ex_flush during EVAL kills the link write and the resolution.
    id_valid = 1'b1; id_op = `OP_BL; id_inst = 32'h0000_1000; id_pc = 32'h1C00_0600;
    tick();
    id_valid = 1'b0;
    ex_flush = 1'b1;
    #1;
    chk("exf_eval.link_we", 32'(link_we), 32'd0);
    tick();
    ex_flush = 1'b0;
    #1;
    chk("exf_eval.br_valid", 32'(br_valid), 32'd0);
    chk("exf_eval.br_adef",  32'(br_adef),  32'd0);
    chk("exf_eval.id_ready", 32'(id_ready), 32'd1);
    chk_stats("exf_eval");

    // Back-to-back not-taken branches with id_valid held high.
    id_valid = 1'b1; id_op = `OP_BLTU; id_inst = 32'h0000_1000;
    id_pc = 32'h1C00_0700; rj_value = 32'hFFFF_FFFF; rkd_value = 32'd1;
    #1;
    chk("b2b.accept0", 32'(id_ready), 32'd1);
    tick();
    chk("b2b.busy0", 32'(id_ready), 32'd0);
    tick();
    chk("b2b.accept1", 32'(id_ready), 32'd1);
    exp_bj++;
    tick();
    id_valid = 1'b0;
    #1;
    chk("b2b.busy1", 32'(id_ready), 32'd0);
    tick();
    exp_bj++;
    chk("b2b.idle",     32'(id_ready), 32'd1);
    chk("b2b.br_valid", 32'(br_valid), 32'd0);
    chk_stats("b2b");

    // Randomized branches.
    for (int n = 0; n < 150; n++) begin
      logic [7:0]  op;
      logic [31:0] rj;
      logic [31:0] rkd;
      op  = ops[$urandom_range(0, 9)];
      rj  = $urandom;
      rkd = ($urandom_range(0, 3) == 0) ? rj : 32'($urandom);
      if ((op == `OP_JIRL) && ($urandom_range(0, 1) == 0)) rj[1:0] = 2'b00;
      run_branch($sformatf("rnd%0d", n), op, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 rj, rkd, int'($urandom_range(0, 3)));
    end

    // Reset while a redirect is pending drops it.
    id_valid = 1'b1; id_op = `OP_B; id_inst = 32'h0000_1000; id_pc = 32'h1C00_0800;
    tick();
    id_valid = 1'b0;
    tick();
    chk("rst_mid.br_valid_pre", 32'(br_valid), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_bj    = 0;
    exp_taken = 0;
    #1;
    chk("rst_mid.br_valid", 32'(br_valid), 32'd0);
    chk("rst_mid.id_ready", 32'(id_ready), 32'd1);
    chk_stats("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
